// File: rtl/speech256_pkg.sv
// Shared Speech256 types and constants for the coefficient receive path.
package speech256_pkg;

    localparam int unsigned NSECT_DEF = 6;
    localparam int unsigned CW_DEF    = 10;
    localparam int unsigned WORDS_DEF = 2 * NSECT_DEF;
    localparam int unsigned WIW_DEF   = $clog2(WORDS_DEF);

    // Frame word order: F on even word index, B on odd.
    localparam logic WORD_F = 1'b0;
    localparam logic WORD_B = 1'b1;

    typedef enum logic {
        S_IDLE,
        S_RECV
    } rx_state_t;

    function automatic logic is_b_word(input logic lsb);
        return lsb == WORD_B;
    endfunction

endpackage

// File: rtl/coeff_rx_if.sv
// Coefficient stream from the controller: word, strobe and pitch-period pulse.
interface coeff_rx_if #(
    parameter int unsigned CW = speech256_pkg::CW_DEF
);
    logic [CW-1:0] coeff_in;
    logic          coeff_stb;
    logic          period_done_in;

    modport master (output coeff_in, output coeff_stb, output period_done_in);
    modport slave  (input  coeff_in, input  coeff_stb, input  period_done_in);
endinterface

// File: rtl/coeff_bank.sv
// Shadow/active coefficient bank: indexed shadow write, whole-bank swap, registered read.
module coeff_bank
    import speech256_pkg::*;
#(
    parameter int unsigned NSECT = NSECT_DEF,
    parameter int unsigned CW    = CW_DEF,
    parameter int unsigned WIW   = $clog2(2 * NSECT)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en,
    input  logic [WIW-1:0] wr_idx,
    input  logic [CW-1:0]  wr_data,
    input  logic           swap,
    input  logic [2:0]     rd_sel,
    output logic [CW-1:0]  rd_f,
    output logic [CW-1:0]  rd_b
);
    localparam int unsigned SW = (NSECT > 1) ? $clog2(NSECT) : 1;

    logic [CW-1:0] shadow_f [NSECT];
    logic [CW-1:0] shadow_b [NSECT];
    logic [CW-1:0] active_f [NSECT];
    logic [CW-1:0] active_b [NSECT];

    logic [SW-1:0] wr_sect;
    logic [SW-1:0] rd_sect;
    logic          rd_ok;

    assign wr_sect = SW'(wr_idx >> 1);
    assign rd_sect = SW'(rd_sel);
    assign rd_ok   = 32'(rd_sel) < NSECT;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_f <= '{default: '0};
            shadow_b <= '{default: '0};
            active_f <= '{default: '0};
            active_b <= '{default: '0};
            rd_f     <= '0;
            rd_b     <= '0;
        end else begin
            // Copy reads pre-write shadow, so a same-cycle word 0 lands only in shadow.
            if (swap) begin
                active_f <= shadow_f;
                active_b <= shadow_b;
            end
            if (wr_en) begin
                if (is_b_word(wr_idx[0])) shadow_b[wr_sect] <= wr_data;
                else                      shadow_f[wr_sect] <= wr_data;
            end
            rd_f <= rd_ok ? active_f[rd_sect] : '0;
            rd_b <= rd_ok ? active_b[rd_sect] : '0;
        end
    end

endmodule

// File: rtl/coeff_rx.sv
// Speech256 coefficient receiver: frames F/B words into a shadow bank, swaps on period boundary.
module coeff_rx
    import speech256_pkg::*;
#(
    parameter int unsigned NSECT          = NSECT_DEF,
    parameter int unsigned CW             = CW_DEF,
    parameter int unsigned GAP_MAX        = 4,
    parameter int unsigned SWAP_ON_PERIOD = 1
) (
    input  logic             clk,
    input  logic             rst,
    coeff_rx_if.slave        coeff_bus,
    input  logic [2:0]       rd_sel,
    output logic [CW-1:0]    rd_f,
    output logic [CW-1:0]    rd_b,
    output logic             frame_pending,
    output logic             swap_stb,
    output logic             overrun,
    output logic             gap_err,
    input  logic             err_clr
);
    localparam int unsigned WIW = $clog2(2 * NSECT);
    localparam int unsigned GW  = $clog2(GAP_MAX + 1);
    localparam logic [WIW-1:0] LAST_W   = WIW'(2 * NSECT - 1);
    localparam logic [GW-1:0]  GAP_LAST = GW'(GAP_MAX - 1);

    rx_state_t      state;
    logic [WIW-1:0] widx;
    logic [GW-1:0]  gap;
    logic           swap;

    assign swap = frame_pending && (coeff_bus.period_done_in || (SWAP_ON_PERIOD == 0));

    // widx is always 0 in S_IDLE, so the strobe alone qualifies the shadow write.
    coeff_bank #(
        .NSECT (NSECT),
        .CW    (CW),
        .WIW   (WIW)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (coeff_bus.coeff_stb),
        .wr_idx  (widx),
        .wr_data (coeff_bus.coeff_in),
        .swap    (swap),
        .rd_sel  (rd_sel),
        .rd_f    (rd_f),
        .rd_b    (rd_b)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            widx          <= '0;
            gap           <= '0;
            frame_pending <= 1'b0;
            swap_stb      <= 1'b0;
            overrun       <= 1'b0;
            gap_err       <= 1'b0;
        end else begin
            swap_stb <= swap;
            if (err_clr) begin
                overrun <= 1'b0;
                gap_err <= 1'b0;
            end
            if (swap) frame_pending <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (coeff_bus.coeff_stb) begin
                        widx  <= WIW'(1);
                        gap   <= '0;
                        state <= S_RECV;
                        if (frame_pending && !swap) begin
                            overrun       <= 1'b1;
                            frame_pending <= 1'b0;
                        end
                    end
                end
                S_RECV: begin
                    if (coeff_bus.coeff_stb) begin
                        gap <= '0;
                        if (widx == LAST_W) begin
                            frame_pending <= 1'b1;
                            widx          <= '0;
                            state         <= S_IDLE;
                        end else begin
                            widx <= widx + 1'b1;
                        end
                    end else if (gap == GAP_LAST) begin
                        gap_err <= 1'b1;
                        gap     <= '0;
                        widx    <= '0;
                        state   <= S_IDLE;
                    end else begin
                        gap <= gap + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_coeff_rx.sv
// Directed bench for coeff_rx: framing, swap timing, gap abort, overrun, reset.
module tb_coeff_rx;
    import speech256_pkg::*;

    localparam int unsigned CW = 10;

    logic       clk;
    logic       rst;
    logic [2:0] rd_sel;
    logic [CW-1:0] rd_f;
    logic [CW-1:0] rd_b;
    logic       frame_pending;
    logic       swap_stb;
    logic       overrun;
    logic       gap_err;
    logic       err_clr;

    int n_assert = 0;
    int n_fail   = 0;

    coeff_rx_if #(.CW(CW)) bus ();

    coeff_rx #(
        .NSECT          (6),
        .CW             (CW),
        .GAP_MAX        (4),
        .SWAP_ON_PERIOD (1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .coeff_bus     (bus),
        .rd_sel        (rd_sel),
        .rd_f          (rd_f),
        .rd_b          (rd_b),
        .frame_pending (frame_pending),
        .swap_stb      (swap_stb),
        .overrun       (overrun),
        .gap_err       (gap_err),
        .err_clr       (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic word(input int v);
        logic [CW-1:0] w;
        w = CW'(v);
        bus.coeff_in  = w;
        bus.coeff_stb = 1'b1;
        tick();
        bus.coeff_stb = 1'b0;
    endtask

    task automatic period_tick();
        bus.period_done_in = 1'b1;
        tick();
        bus.period_done_in = 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        err_clr = 1'b0;
        rd_sel = 3'd2;
        bus.coeff_in = '0;
        bus.coeff_stb = 1'b0;
        bus.period_done_in = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_rd_f", $signed(rd_f), 0);
        chk("rst_rd_b", $signed(rd_b), 0);
        chk("rst_pending", frame_pending, 0);
        chk("rst_swap_stb", swap_stb, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_gap_err", gap_err, 0);
        chk("rst_state", dut.state, S_IDLE);
        rst = 1'b0;

        // Frame 1..12, then period pulse on the 5th cycle after
        for (int i = 1; i <= 12; i++) word(i);
        chk("t1_pending", frame_pending, 1);
        chk("t1_rd_f_pre", $signed(rd_f), 0);
        repeat (4) tick();
        chk("t1_rd_b_pre", $signed(rd_b), 0);
        chk("t1_swap_pre", swap_stb, 0);
        period_tick();
        chk("t1_swap_stb", swap_stb, 1);
        chk("t1_pending_clr", frame_pending, 0);
        chk("t1_rd_f_lat", $signed(rd_f), 0);
        tick();
        chk("t1_swap_once", swap_stb, 0);
        chk("t1_rd_f", $signed(rd_f), 5);
        chk("t1_rd_b", $signed(rd_b), 6);

        // Frame completing on the same edge as period_done_in
        for (int i = 1; i <= 11; i++) word(20 + i);
        bus.period_done_in = 1'b1;
        word(32);
        bus.period_done_in = 1'b0;
        chk("t2_pending", frame_pending, 1);
        chk("t2_no_swap", swap_stb, 0);
        cnt = 0;
        repeat (39) begin
            tick();
            if (swap_stb) cnt++;
        end
        chk("t2_idle_swaps", cnt, 0);
        chk("t2_rd_f_old", $signed(rd_f), 5);
        period_tick();
        chk("t2_swap_stb", swap_stb, 1);
        tick();
        chk("t2_swap_once", swap_stb, 0);
        chk("t2_rd_f", $signed(rd_f), 25);
        chk("t2_rd_b", $signed(rd_b), 26);

        // Gap abort after 5 words
        for (int i = 1; i <= 5; i++) word(50 + i);
        repeat (3) tick();
        chk("t3_gap_early", gap_err, 0);
        chk("t3_state_recv", dut.state, S_RECV);
        tick();
        chk("t3_gap_err", gap_err, 1);
        chk("t3_state_idle", dut.state, S_IDLE);
        chk("t3_pending", frame_pending, 0);
        for (int i = 1; i <= 12; i++) word(-i);
        chk("t3_pending2", frame_pending, 1);
        rd_sel = 3'd0;
        period_tick();
        tick();
        chk("t3_rd_f", $signed(rd_f), -1);
        chk("t3_rd_b", $signed(rd_b), -2);
        chk("t3_gap_sticky", gap_err, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t3_gap_clr", gap_err, 0);

        // Overrun: A completes, B starts before any period pulse
        rd_sel = 3'd2;
        for (int i = 1; i <= 12; i++) word(60 + i);
        tick();
        chk("t4_pending_a", frame_pending, 1);
        chk("t4_no_ovr", overrun, 0);
        err_clr = 1'b1;
        word(81);
        err_clr = 1'b0;
        chk("t4_overrun_setwins", overrun, 1);
        chk("t4_pending_drop", frame_pending, 0);
        for (int i = 2; i <= 12; i++) word(80 + i);
        chk("t4_pending_b", frame_pending, 1);
        period_tick();
        tick();
        chk("t4_rd_f", $signed(rd_f), 85);
        chk("t4_rd_b", $signed(rd_b), 86);
        chk("t4_ovr_sticky", overrun, 1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        chk("t4_ovr_clr", overrun, 0);

        // Swap coincident with word 0 of the next frame
        for (int i = 1; i <= 12; i++) word(100 + i);
        tick();
        bus.period_done_in = 1'b1;
        word(201);
        bus.period_done_in = 1'b0;
        chk("t5_swap_stb", swap_stb, 1);
        chk("t5_no_ovr", overrun, 0);
        chk("t5_pending", frame_pending, 0);
        chk("t5_state", dut.state, S_RECV);
        word(202);
        chk("t5_rd_f_old", $signed(rd_f), 105);
        chk("t5_rd_b_old", $signed(rd_b), 106);
        for (int i = 3; i <= 12; i++) word(200 + i);
        chk("t5_pending2", frame_pending, 1);
        period_tick();
        tick();
        chk("t5_rd_f_new", $signed(rd_f), 205);
        chk("t5_rd_b_new", $signed(rd_b), 206);
        chk("t5_ovr_end", overrun, 0);

        // Reset mid-frame after word 7
        for (int i = 1; i <= 7; i++) word(300 + i);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rd_f", $signed(rd_f), 0);
        chk("t6_rd_b", $signed(rd_b), 0);
        chk("t6_pending", frame_pending, 0);
        chk("t6_swap_stb", swap_stb, 0);
        chk("t6_state", dut.state, S_IDLE);
        tick();
        chk("t6_active_zero", $signed(rd_f), 0);
        for (int i = 1; i <= 12; i++) word(400 + i);
        chk("t6_pending2", frame_pending, 1);
        rd_sel = 3'd5;
        period_tick();
        tick();
        chk("t6_rd_f5", $signed(rd_f), 411);
        chk("t6_rd_b5", $signed(rd_b), 412);
        rd_sel = 3'd6;
        tick();
        chk("t6_rd_f_oob", $signed(rd_f), 0);
        chk("t6_rd_b_oob", $signed(rd_b), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
